// File: rtl/seg7_bcd_display_driver.sv
// Binary-to-BCD (double-dabble) converter feeding a 3-digit multiplexed seven-segment display.
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN blanks leading zero digits on the display only.
module seg7_bcd_display_driver #(
  parameter int unsigned SCAN_PERIOD = 50000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [7:0]  value,
  output logic [11:0] bcd_out,
  output logic        busy,
  output logic [2:0]  digit_en,
  output logic [6:0]  seg_out
);

  localparam logic [1:0]  ST_IDLE  = 2'd0;
  localparam logic [1:0]  ST_SHIFT = 2'd1;
  localparam logic [1:0]  ST_DONE  = 2'd2;
  localparam logic [19:0] SCAN_LAST = 20'(SCAN_PERIOD - 1);

  logic [1:0]  state;
  logic [7:0]  last_value;
  logic [19:0] shreg;
  logic [2:0]  iter;
  logic [19:0] shift_next;
  logic [19:0] prescaler;
  logic [1:0]  digit_idx;
  logic [1:0]  idx_next;
  logic        scan_wrap;
  logic [3:0]  nib_next;
  logic [6:0]  seg_next;
  logic [2:0]  en_next;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // Add-3 correction and the left shift happen in the same iteration.
  always_comb begin
    shift_next = {add3(shreg[19:16]), add3(shreg[15:12]), add3(shreg[11:8]), shreg[7:0]} << 1;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      bcd_out    <= 12'h000;
      last_value <= 8'd0;
      shreg      <= 20'd0;
      iter       <= 3'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (value != last_value) begin
            shreg      <= {12'd0, value};
            last_value <= value;
            iter       <= 3'd0;
            busy       <= 1'b1;
            state      <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          shreg <= shift_next;
          if (iter == 3'd7) state <= ST_DONE;
          else              iter  <= iter + 3'd1;
        end
        ST_DONE: begin
          bcd_out <= shreg[19:8];
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Enable and pattern come from the same next index so they switch on the same edge.
  always_comb begin
    scan_wrap = (prescaler == SCAN_LAST);
    idx_next  = digit_idx;
    if (scan_wrap) idx_next = (digit_idx == 2'd2) ? 2'd0 : digit_idx + 2'd1;
    case (idx_next)
      2'd0:    begin nib_next = bcd_out[3:0];  en_next = 3'b001; end
      2'd1:    begin nib_next = bcd_out[7:4];  en_next = 3'b010; end
      default: begin nib_next = bcd_out[11:8]; en_next = 3'b100; end
    endcase
    seg_next = seg7(nib_next);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (idx_next == 2'd2 && bcd_out[11:8] == 4'd0) seg_next = 7'h00;
    if (idx_next == 2'd1 && bcd_out[11:4] == 8'd0) seg_next = 7'h00;
`endif
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      prescaler <= 20'd0;
      digit_idx <= 2'd0;
      digit_en  <= 3'b001;
      seg_out   <= 7'h3F;
    end else begin
      prescaler <= scan_wrap ? 20'd0 : prescaler + 20'd1;
      digit_idx <= idx_next;
      digit_en  <= en_next;
      seg_out   <= seg_next;
    end
  end

endmodule

// File: tb/tb_seg7_bcd_display_driver.sv
// Bench for seg7_bcd_display_driver: scoreboard of expected conversion results plus directed scan checks.
module tb_seg7_bcd_display_driver;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [7:0]  value;
  logic [11:0] bcd_out;
  logic        busy;
  logic [2:0]  digit_en;
  logic [6:0]  seg_out;

  typedef struct {
    logic [11:0] bcd;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   sk       = 0;
  logic rst_at_edge = 1'b1;
  logic prev_busy   = 1'b0;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = 7'h00;
`else
  localparam logic [6:0] LZ = 7'h3F;
`endif

  seg7_bcd_display_driver #(.SCAN_PERIOD(4)) dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .value    (value),
    .bcd_out  (bcd_out),
    .busy     (busy),
    .digit_en (digit_en),
    .seg_out  (seg_out)
  );

  always #5 clk_in = ~clk_in;

  // Edge counter and scan model: the scan index advances every 4 edges after reset.
  always @(posedge clk_in) begin
    cyc++;
    rst_at_edge = rst_in;
    if (rst_in) sk = 0;
    else        sk++;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: a falling busy outside reset is a completed conversion.
  always @(negedge clk_in) begin
    exp_t e;
    if (!rst_at_edge && prev_busy && !busy) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: bcd_out=%0h with empty scoreboard", bcd_out);
      end else begin
        e = sb.pop_front();
        check("bcd_out", 32'(bcd_out), 32'(e.bcd));
        check("done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    prev_busy = busy;
  end

  task automatic convert(input logic [7:0] v, input logic [11:0] exp_bcd);
    exp_t e;
    value = v;
    e.bcd = exp_bcd;
    e.cyc = cyc + 10;
    sb.push_back(e);
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk_in);
      check("busy_during_conv", 32'(busy), 32'd1);
    end
    repeat (3) @(negedge clk_in);
  endtask

  task automatic check_scan(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2);
    logic [6:0] segs [3];
    int idx;
    segs[0] = s0; segs[1] = s1; segs[2] = s2;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_in);
      idx = (sk / 4) % 3;
      check("scan_pair", 32'({digit_en, seg_out}), 32'({3'(3'b001 << idx), segs[idx]}));
    end
  endtask

  initial begin
    exp_t e;
    rst_in = 1'b1;
    value  = 8'd0;
    repeat (2) @(negedge clk_in);
    check("rst_bcd_out", 32'(bcd_out), 32'h000);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_digit_en", 32'(digit_en), 32'b001);
    check("rst_seg_out", 32'(seg_out), 32'h3F);
    rst_in = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in);
      check("idle_no_conv", 32'(busy), 32'd0);
    end

    convert(8'd9,   12'h009);
    convert(8'd255, 12'h255);
    convert(8'd100, 12'h100);

    convert(8'd123, 12'h123);
    check_scan(7'h4F, 7'h5B, 7'h06);

    convert(8'd7, 12'h007);
    check_scan(7'h07, LZ, LZ);

    convert(8'd105, 12'h105);
    check_scan(7'h6D, 7'h3F, 7'h06);

    // Change arriving mid-conversion is picked up only after DONE.
    value = 8'd10;
    e.bcd = 12'h010; e.cyc = cyc + 10; sb.push_back(e);
    e.bcd = 12'h020; e.cyc = cyc + 20; sb.push_back(e);
    repeat (2) @(negedge clk_in);
    value = 8'd20;
    repeat (22) @(negedge clk_in);
    check("mid_change_bcd", 32'(bcd_out), 32'h020);

    // Reset in the middle of SHIFT discards the partial result.
    value = 8'd200;
    repeat (4) @(negedge clk_in);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst_in = 1'b1;
    @(negedge clk_in);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_bcd_out", 32'(bcd_out), 32'h000);
    check("midrst_digit_en", 32'(digit_en), 32'b001);
    check("midrst_seg_out", 32'(seg_out), 32'h3F);
    rst_in = 1'b0;
    e.bcd = 12'h200; e.cyc = cyc + 10; sb.push_back(e);
    repeat (14) @(negedge clk_in);
    check_scan(7'h3F, 7'h3F, 7'h5B);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seg7_bcd_display_driver.md
Name: seg7_bcd_display_driver

Overview:
- Downstream consumer of the 8-bit counter value that currently drives the LED array.
- Converts the binary value (0..255) to three BCD digits with a sequential shift-add-3 (double-dabble) FSM.
- Drives a 3-digit multiplexed seven-segment display through a time-scanned digit enable.
- Sits at board top level between the counter output and the display pins, clocked from CLK_50M.

Parameters:
- SCAN_PERIOD, 50000: clk_in cycles each digit stays enabled (1 kHz digit rate at 50 MHz). Legal range 2..2^20-1; prescaler is 20 bits.

Ports:
- clk_in  input  1  system clock (CLK_50M at top level)
- rst_in  input  1  synchronous, active-high reset
- value  input  8  binary value from counter, sampled every cycle
- bcd_out  output  12  {hundreds, tens, units} BCD of last completed conversion
- busy  output  1  high while a conversion is in progress
- digit_en  output  3  one-hot active-high digit select: [0] units, [1] tens, [2] hundreds
- seg_out  output  7  {g,f,e,d,c,b,a}, active-high segment pattern for the enabled digit

Behaviour:
- Reset (clk_in edge with rst_in=1), all registers:
  - state=IDLE, busy=0, bcd_out=12'h000, last_value=8'd0
  - prescaler=0, digit index=0, digit_en=3'b001, seg_out=7'h3F
  - rst_in overrides any in-flight conversion; partial result discarded.
- Conversion FSM, states IDLE, SHIFT, DONE:
  - IDLE: if value != last_value, load shift register with value, last_value<=value, iteration count<=0, busy<=1, go to SHIFT. Else remain in IDLE.
  - SHIFT: one iteration per cycle. Each BCD nibble >=5 gets +3, then the 20-bit {bcd, bin} register shifts left by 1 (add and shift in the same cycle). After iteration 8, go to DONE.
  - DONE: bcd_out<=result, busy<=0, go to IDLE.
- Latency, edge count starting at the IDLE edge that detects the change:
  - busy high after edge 1.
  - bcd_out updated and busy low after edge 10.
  - seg_out reflects the new bcd_out one cycle later.
- Changes on value during SHIFT/DONE are ignored. The next IDLE cycle re-compares against last_value and restarts, so the final bcd_out always matches a stable value.
- bcd_out holds between conversions. Nibbles are always 0..9.
- Scan:
  - Prescaler counts 0..SCAN_PERIOD-1 and wraps.
  - At the terminal count the digit index advances 0->1->2->0.
  - digit_en and seg_out are registered together from the same next index, so they never disagree for a cycle.
  - Exactly one digit_en bit is high at all times after reset.
- seg_out is re-registered every cycle from the current index and bcd_out.
  - Decode: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F.
  - Any other nibble decodes to 00 (unreachable).
- Scanning continues independently of conversion activity.

Optional Feature:
- Macro SEG7_LEADING_ZERO_BLANK_EN.
- When defined:
  - Hundreds digit shows seg_out=7'h00 when the hundreds nibble is 0.
  - Tens digit shows 7'h00 when both hundreds and tens are 0.
  - Units digit is never blanked.
  - digit_en scanning is unchanged.
- When undefined: all three digits always show their decoded nibble, including leading zeros.
- bcd_out is identical in both builds.

Test Plan:
- Reset with value=0 -> bcd_out=12'h000, busy=0, digit_en=3'b001, seg_out=7'h3F; busy stays 0 for 20 cycles (no false conversion).
- value 0->9 held -> busy=1 on edges 1..9, bcd_out=12'h009 and busy=0 after edge 10. Repeat with 255 -> 12'h255, with 100 -> 12'h100.
- SCAN_PERIOD=4, value=123 settled -> repeating {digit_en,seg_out} pattern (001,4F), (010,5B), (100,06), each pair held exactly 4 cycles.
- value=10, then 20 applied on edge 3 of that conversion -> bcd_out=12'h010 at edge 10, new conversion starts edge 11, bcd_out=12'h020 at edge 20.
- rst_in pulsed mid-SHIFT for value=200 -> reset values next cycle. value still 200 after release -> fresh conversion, bcd_out=12'h200 10 edges later.
- Build with SEG7_LEADING_ZERO_BLANK_EN, SCAN_PERIOD=4:
  - value=7 -> units seg 07, tens 00, hundreds 00.
  - value=105 -> tens shows 3F (not blanked).
  - Without the macro, value=7 -> 07/3F/3F.
